// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with a write-only register window.
// Outputs are registered from the DATA/CTRL/index state of the previous cycle.
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [7:0]  dig_en,
  output logic        DN_A,
  output logic        DN_B,
  output logic        DN_C,
  output logic        DN_D,
  output logic        DN_E,
  output logic        DN_F,
  output logic        DN_G,
  output logic        DN_DP
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

  logic [31:0] data;
  logic [7:0]  mask;
  logic        lzb;
  logic [15:0] cnt;
  logic [2:0]  idx;

  logic [6:0]  seg_q;
  logic        dp_q;

  logic [4:0]  nib_lsb;
  logic [3:0]  nibble;
  logic        upper_zero;
  logic        blank;
  logic [7:0]  dig_next;
  logic [6:0]  seg_next;

  // Active-high gfedcba pattern for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Leading-zero blanking looks at every nibble from the current digit upward.
  always_comb begin
    nib_lsb    = {idx, 2'b00};
    nibble     = data[nib_lsb +: 4];
    upper_zero = ((data >> nib_lsb) == 32'd0);
    blank      = !mask[idx] || (lzb && (idx != 3'd0) && upper_zero);
    dig_next   = 8'hFF;
    seg_next   = 7'h7F;
    if (!blank) begin
      dig_next = ~(8'h01 << idx);
      seg_next = ~hex_to_seg(nibble);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data   <= 32'd0;
      mask   <= 8'hFF;
      lzb    <= 1'b0;
      cnt    <= 16'd0;
      idx    <= 3'd0;
      dig_en <= 8'hFF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= 16'd0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 16'd1;
      end
      if (wen && (addr == 12'h000)) begin
        data <= wdata;
      end
      if (wen && (addr == 12'h004)) begin
        mask <= wdata[7:0];
        lzb  <= wdata[8];
      end
      dig_en <= dig_next;
      seg_q  <= seg_next;
      dp_q   <= 1'b1;
    end
  end

  assign DN_A  = seg_q[0];
  assign DN_B  = seg_q[1];
  assign DN_C  = seg_q[2];
  assign DN_D  = seg_q[3];
  assign DN_E  = seg_q[4];
  assign DN_F  = seg_q[5];
  assign DN_G  = seg_q[6];
  assign DN_DP = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (SCAN_DIV=4): directed scenarios plus random writes,
// checked each cycle against a frame-position model of the display.
module tb_seg7_scan_ctrl;

  localparam int SD = 4;

  logic        clk;
  logic        rst;
  logic [11:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [7:0]  dig_en;
  logic        DN_A, DN_B, DN_C, DN_D, DN_E, DN_F, DN_G, DN_DP;

  int errors = 0;
  int checks = 0;

  // Reference state: registers plus cycles elapsed since the last reset.
  logic [31:0] m_data;
  logic [7:0]  m_mask;
  logic        m_lzb;
  int          m_t;
  logic [7:0]  exp_dig;
  logic [6:0]  exp_seg;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg7_scan_ctrl #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata),
    .dig_en(dig_en),
    .DN_A(DN_A), .DN_B(DN_B), .DN_C(DN_C), .DN_D(DN_D),
    .DN_E(DN_E), .DN_F(DN_F), .DN_G(DN_G), .DN_DP(DN_DP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs_seg();
    return {DN_G, DN_F, DN_E, DN_D, DN_C, DN_B, DN_A};
  endfunction

  // Advance one clock: predict what the pins show after this edge, then update the model.
  task automatic step();
    int          d;
    int unsigned nib;
    logic [31:0] upper;
    logic        blank;
    if (rst) begin
      exp_dig = 8'hFF;
      exp_seg = 7'h7F;
      m_data  = 32'd0;
      m_mask  = 8'hFF;
      m_lzb   = 1'b0;
      m_t     = 0;
    end else begin
      d     = (m_t / SD) % 8;
      nib   = (m_data / (32'd1 << (4 * d))) % 16;
      upper = m_data / (32'd1 << (4 * d));
      blank = (m_mask[d] == 1'b0) || (m_lzb && d > 0 && upper == 0);
      exp_dig = blank ? 8'hFF : 8'(~(32'd1 << d));
      exp_seg = blank ? 7'h7F : ~SEG_TAB[nib];
      if (wen && addr == 12'h000) m_data = wdata;
      if (wen && addr == 12'h004) begin
        m_mask = wdata[7:0];
        m_lzb  = wdata[8];
      end
      m_t = m_t + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    step();
    wen   = 1'b0;
    addr  = 12'h000;
    wdata = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (dig_en !== 8'hFF || obs_seg() !== 7'h7F || DN_DP !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_hold: dig_en=%h seg=%h dp=%b, required FF/7F/1", dig_en, obs_seg(), DN_DP);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (dig_en !== 8'hFE || obs_seg() !== 7'h40 || DN_DP !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release: dig_en=%h seg=%h dp=%b, required FE/40/1", dig_en, obs_seg(), DN_DP);
    end
  endtask

  task automatic test_idle_scan();
    for (int i = 0; i < 32; i++) begin
      step();
      checks++;
      if (dig_en !== exp_dig || obs_seg() !== 7'h40 || DN_DP !== 1'b1) begin
        errors++;
        $display("[TB] FAIL idle_scan[%0d]: dig_en=%h seg=%h, required %h/40", i, dig_en, obs_seg(), exp_dig);
      end
    end
  endtask

  task automatic test_hex_data();
    applyStimulus(12'h000, 32'h89ABCDEF);
    for (int i = 0; i < 33; i++) begin
      step();
      checks++;
      if (dig_en !== exp_dig || obs_seg() !== exp_seg || DN_DP !== 1'b1) begin
        errors++;
        $display("[TB] FAIL hex_data[%0d]: dig_en=%h seg=%h, required %h/%h", i, dig_en, obs_seg(), exp_dig, exp_seg);
      end
      if (exp_dig == 8'hFE) begin
        checks++;
        if (obs_seg() !== 7'h0E) begin
          errors++;
          $display("[TB] FAIL hex_digit0_F: seg=%h, required 0E", obs_seg());
        end
      end
      if (exp_dig == 8'h7F) begin
        checks++;
        if (obs_seg() !== 7'h00 || DN_DP !== 1'b1) begin
          errors++;
          $display("[TB] FAIL hex_digit7_8: seg=%h dp=%b, required 00/1", obs_seg(), DN_DP);
        end
      end
    end
  endtask

  task automatic test_mask();
    applyStimulus(12'h004, 32'h0000_00F0);
    for (int i = 0; i < 33; i++) begin
      step();
      checks++;
      if (dig_en !== exp_dig || obs_seg() !== exp_seg) begin
        errors++;
        $display("[TB] FAIL mask[%0d]: dig_en=%h seg=%h, required %h/%h", i, dig_en, obs_seg(), exp_dig, exp_seg);
      end
    end
  endtask

  task automatic test_lzb();
    int lit [8];
    applyStimulus(12'h000, 32'h0000_0120);
    applyStimulus(12'h004, 32'h0000_01FF);
    step();
    for (int k = 0; k < 8; k++) lit[k] = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      checks++;
      if (dig_en !== exp_dig || obs_seg() !== exp_seg) begin
        errors++;
        $display("[TB] FAIL lzb[%0d]: dig_en=%h seg=%h, required %h/%h", i, dig_en, obs_seg(), exp_dig, exp_seg);
      end
      for (int k = 0; k < 8; k++) if (dig_en[k] === 1'b0) lit[k]++;
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (lit[k] != ((k < 3) ? SD : 0)) begin
        errors++;
        $display("[TB] FAIL lzb_slot_len[%0d]: lit %0d cycles, required %0d", k, lit[k], (k < 3) ? SD : 0);
      end
    end
  endtask

  task automatic test_wrap_write();
    logic [31:0] nd;
    applyStimulus(12'h004, 32'h0000_00FF);
    for (int i = 0; i < 40 && (m_t % (8 * SD)) != (8 * SD - 1); i++) step();
    nd = $urandom;
    applyStimulus(12'h000, nd);
    checks++;
    if (dig_en !== 8'h7F) begin
      errors++;
      $display("[TB] FAIL wrap_pre: dig_en=%h, required 7F", dig_en);
    end
    step();
    checks++;
    if (dig_en !== 8'hFE || obs_seg() !== ~SEG_TAB[nd[3:0]]) begin
      errors++;
      $display("[TB] FAIL wrap_new_data: dig_en=%h seg=%h, required FE/%h", dig_en, obs_seg(), ~SEG_TAB[nd[3:0]]);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (dig_en !== exp_dig || obs_seg() !== exp_seg) begin
        errors++;
        $display("[TB] FAIL wrap_follow[%0d]: dig_en=%h seg=%h, required %h/%h", i, dig_en, obs_seg(), exp_dig, exp_seg);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8 && (m_t % SD) != 2; i++) step();
    rst   = 1'b1;
    wen   = 1'b1;
    addr  = 12'h000;
    wdata = 32'h1234_5678;
    step();
    rst   = 1'b0;
    wen   = 1'b0;
    wdata = 32'd0;
    checks++;
    if (dig_en !== 8'hFF || obs_seg() !== 7'h7F || DN_DP !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_hold: dig_en=%h seg=%h, required FF/7F", dig_en, obs_seg());
    end
    for (int i = 0; i < 8 * SD; i++) begin
      step();
      checks++;
      if (dig_en !== exp_dig || obs_seg() !== 7'h40) begin
        errors++;
        $display("[TB] FAIL reset_mid_after[%0d]: dig_en=%h seg=%h, required %h/40", i, dig_en, obs_seg(), exp_dig);
      end
    end
  endtask

  task automatic test_random();
    int unsigned r;
    for (int i = 0; i < 400; i++) begin
      r     = $urandom_range(0, 9);
      wen   = (r < 4);
      addr  = (r < 2) ? 12'h000 : (r == 2) ? 12'h004 : 12'($urandom);
      wdata = $urandom;
      step();
      checks++;
      if (dig_en !== exp_dig || obs_seg() !== exp_seg || DN_DP !== 1'b1) begin
        errors++;
        $display("[TB] FAIL random[%0d]: dig_en=%h seg=%h, required %h/%h", i, dig_en, obs_seg(), exp_dig, exp_seg);
      end
    end
    wen  = 1'b0;
    addr = 12'h000;
  endtask

  initial begin
    rst   = 1'b1;
    wen   = 1'b0;
    addr  = 12'h000;
    wdata = 32'd0;
    m_data = 32'd0;
    m_mask = 8'hFF;
    m_lzb  = 1'b0;
    m_t    = 0;
    test_reset();
    test_idle_scan();
    test_hex_data();
    test_mask();
    test_lzb();
    test_wrap_write();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
